ctu_clsp_syncgen: RTL

Sync-pulse transmitter for the CTU clock-sync path. It runs in the CMP/PLL clock domain and divides that clock by a programmable ratio. Each slow-clock period it drives a one-cycle `tx_sync` pulse on the period's first cycle, a one-cycle `rx_sync` pulse on its last cycle, and a `phase` level. Downstream cluster synchronizers consume these to align slow-domain crossings. Ratio changes use a req/ack handshake and take effect only on a period boundary, so no short or long period is ever produced.

---
 rtl/ctu_clsp_syncgen_if.sv | 25 ++
 rtl/ctu_clsp_syncgen.sv | 96 +++++++++
 2 files changed

// File: rtl/ctu_clsp_syncgen_if.sv
// Control/status bundle between a clock-sync controller and the sync-pulse generator.
// The generator side uses the slave modport; the controlling side uses master.
interface ctu_clsp_syncgen_if #(
  parameter int CNT_W = 5
);
  logic             en;
  logic             ratio_req;
  logic [CNT_W-1:0] ratio_in;
  logic             ratio_ack;
  logic             tx_sync;
  logic             rx_sync;
  logic             phase;
  logic             busy;
  logic             ratio_err;

  modport master (
    output en, ratio_req, ratio_in,
    input  ratio_ack, tx_sync, rx_sync, phase, busy, ratio_err
  );

  modport slave (
    input  en, ratio_req, ratio_in,
    output ratio_ack, tx_sync, rx_sync, phase, busy, ratio_err
  );
endinterface

// File: rtl/ctu_clsp_syncgen.sv
// Divides cmp_clk by a programmable ratio and emits tx_sync/rx_sync/phase per slow period.
// Ratio updates are handshaked and only take effect on a period boundary.
module ctu_clsp_syncgen #(
  parameter int CNT_W     = 5,
  parameter int RST_RATIO = 4
) (
  input  logic                cmp_clk,
  input  logic                cmp_rst_l,
  ctu_clsp_syncgen_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_R = CNT_W'(RST_RATIO);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic             ratio_err_q, ratio_err_d;
  logic             ratio_ack_q, ratio_ack_d;

  logic             latch;
  logic             ratio_low;
  logic [CNT_W-1:0] ratio_clamped;
  logic [CNT_W-1:0] ratio_eff;

  always_comb begin
    ratio_low     = (bus.ratio_in < TWO);
    ratio_clamped = ratio_low ? TWO : bus.ratio_in;
    // ratio_ack_q masks the request that was just acknowledged but is still held high.
    latch = bus.ratio_req && !ratio_ack_q &&
            ((state_q == IDLE) || ((state_q == RUN) && (cnt_q == '0))) &&
            !(!bus.en && (state_q != IDLE));
    ratio_eff = latch ? ratio_clamped : ratio_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_eff;
    ratio_ack_d = latch;
    ratio_err_d = ratio_err_q | (latch & ratio_low);

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ALIGN;
          cnt_d   = ratio_eff - ONE;
        end
        ALIGN: begin
          if (cnt_q == '0) begin
            state_d = RUN;
            cnt_d   = ratio_q - ONE;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        RUN: begin
          cnt_d = (cnt_q == '0) ? (ratio_eff - ONE) : (cnt_q - ONE);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cmp_clk or negedge cmp_rst_l) begin
    if (!cmp_rst_l) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ratio_q     <= RST_R;
      ratio_err_q <= 1'b0;
      ratio_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      ratio_err_q <= ratio_err_d;
      ratio_ack_q <= ratio_ack_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign bus.tx_sync   = (state_q == RUN) && (cnt_q == (ratio_q - ONE));
  assign bus.rx_sync   = (state_q == RUN) && (cnt_q == '0);
  assign bus.phase     = (state_q == RUN) && (cnt_q >= (ratio_q >> 1));
  assign bus.busy      = (state_q != IDLE);
  assign bus.ratio_ack = ratio_ack_q;
  assign bus.ratio_err = ratio_err_q;
endmodule
